md_ctrl: RTL and testbench

- Sequencer for the RV32M execute stage.
- Accepts one M-extension op at a time from EX and drives the shared combinational multiplier's operand, signedness and hi/lo select inputs.
- Contains an iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
- Returns a registered result with a one-cycle done pulse; EX stalls on busy.

---
 rtl/md_ctrl_pkg.sv | 26 ++
 rtl/md_ctrl_div_iter.sv | 57 +++++
 rtl/md_ctrl.sv | 159 +++++++++++++++
 tb/tb_md_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the RV32M sequencer: funct3 op codes, FSM states and
// the multiplier interface widths.
package md_ctrl_pkg;

  localparam int MD_DATA_LEN      = 32;
  localparam int MD_OUT_SEL_WIDTH = 2;

  typedef enum logic [2:0] {
    MD_OP_MUL    = 3'd0,
    MD_OP_MULH   = 3'd1,
    MD_OP_MULHSU = 3'd2,
    MD_OP_MULHU  = 3'd3,
    MD_OP_DIV    = 3'd4,
    MD_OP_DIVU   = 3'd5,
    MD_OP_REM    = 3'd6,
    MD_OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_ctrl_div_iter.sv
// Radix-2 restoring divider core: one shift/trial-subtract step per enabled
// cycle on unsigned magnitudes. quo/rem present the post-step values.
module md_ctrl_div_iter #(
  parameter int DATA_LEN = 32,
  parameter int CNT_W    = $clog2(DATA_LEN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                en,
  input  logic [DATA_LEN-1:0] divisor,
  input  logic [DATA_LEN-1:0] dividend,
  output logic                last,
  output logic [DATA_LEN-1:0] quo,
  output logic [DATA_LEN-1:0] rem
);

  logic [DATA_LEN-1:0] rem_q;
  logic [DATA_LEN-1:0] quo_q;
  logic [DATA_LEN-1:0] div_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [DATA_LEN:0]   shifted;
  logic [DATA_LEN:0]   diff;
  logic                q_bit;

  // The partial remainder is always below the divisor, so after shifting it
  // needs one extra bit; a clear MSB of the difference means "fits".
  always_comb begin
    shifted = {rem_q, quo_q[DATA_LEN-1]};
    diff    = shifted - {1'b0, div_q};
    q_bit   = ~diff[DATA_LEN];
    quo     = {quo_q[DATA_LEN-2:0], q_bit};
    rem     = q_bit ? diff[DATA_LEN-1:0] : shifted[DATA_LEN-1:0];
  end

  assign last = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      div_q <= divisor;
      cnt_q <= CNT_W'(DATA_LEN - 1);
    end else if (en) begin
      rem_q <= rem;
      quo_q <= quo;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/md_ctrl.sv
// RV32M execute-stage sequencer: drives the shared multiplier for MUL ops and
// runs the iterative divider for DIV/REM ops, returning a registered result.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int DATA_LEN = MD_DATA_LEN,
  parameter int CNT_W    = $clog2(DATA_LEN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [2:0]                  op,
  input  logic [DATA_LEN-1:0]         src1,
  input  logic [DATA_LEN-1:0]         src2,
  input  logic                        flush,
  output logic                        busy,
  output logic                        done,
  output logic [DATA_LEN-1:0]         result,
  output logic [DATA_LEN-1:0]         mul_src1,
  output logic [DATA_LEN-1:0]         mul_src2,
  output logic                        mul_src1_signed,
  output logic                        mul_src2_signed,
  output logic [MD_OUT_SEL_WIDTH-1:0] mul_md_out_sel,
  input  logic [DATA_LEN-1:0]         mul_result
);

  localparam logic [DATA_LEN-1:0] MIN_NEG = {1'b1, {(DATA_LEN-1){1'b0}}};

  md_state_e           state;
  md_op_e              op_q;
  logic [DATA_LEN-1:0] src1_q;
  logic [DATA_LEN-1:0] src2_q;
  logic                div_first;

  logic                is_signed_div;
  logic                is_rem;
  logic                neg1;
  logic                neg2;
  logic [DATA_LEN-1:0] abs1;
  logic [DATA_LEN-1:0] abs2;
  logic                div_by_zero;
  logic                overflow;
  logic                special;
  logic [DATA_LEN-1:0] special_result;
  logic [DATA_LEN-1:0] fixed_result;
  logic                div_load;
  logic                div_en;
  logic                iter_last;
  logic [DATA_LEN-1:0] iter_quo;
  logic [DATA_LEN-1:0] iter_rem;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // Sign handling and the two RISC-V divide corner cases, all from latched operands.
  always_comb begin
    is_signed_div  = (op_q == MD_OP_DIV) || (op_q == MD_OP_REM);
    is_rem         = (op_q == MD_OP_REM) || (op_q == MD_OP_REMU);
    neg1           = is_signed_div & src1_q[DATA_LEN-1];
    neg2           = is_signed_div & src2_q[DATA_LEN-1];
    abs1           = neg1 ? -src1_q : src1_q;
    abs2           = neg2 ? -src2_q : src2_q;
    div_by_zero    = (src2_q == '0);
    overflow       = is_signed_div && (src1_q == MIN_NEG) && (src2_q == '1);
    special        = div_by_zero | overflow;
    special_result = '0;
    if (div_by_zero)
      special_result = is_rem ? src1_q : '1;
    else if (overflow)
      special_result = is_rem ? '0 : MIN_NEG;
    if (is_rem)
      fixed_result = neg1 ? -iter_rem : iter_rem;
    else
      fixed_result = (neg1 ^ neg2) ? -iter_quo : iter_quo;
  end

  assign div_load = (state == ST_DIV) && div_first && !special;
  assign div_en   = (state == ST_DIV) && !div_first;

  md_ctrl_div_iter #(
    .DATA_LEN (DATA_LEN),
    .CNT_W    (CNT_W)
  ) u_div_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .en       (div_en),
    .divisor  (abs2),
    .dividend (abs1),
    .last     (iter_last),
    .quo      (iter_quo),
    .rem      (iter_rem)
  );

  // Control FSM; flush overrides everything and never touches result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      op_q            <= MD_OP_MUL;
      src1_q          <= '0;
      src2_q          <= '0;
      div_first       <= 1'b0;
      result          <= '0;
      mul_src1        <= '0;
      mul_src2        <= '0;
      mul_src1_signed <= 1'b0;
      mul_src2_signed <= 1'b0;
      mul_md_out_sel  <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      div_first <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            op_q   <= md_op_e'(op);
            src1_q <= src1;
            src2_q <= src2;
            if (!op[2]) begin
              state           <= ST_MUL;
              mul_src1        <= src1;
              mul_src2        <= src2;
              mul_src1_signed <= (op != MD_OP_MULHU);
              mul_src2_signed <= (op == MD_OP_MUL) || (op == MD_OP_MULH);
              mul_md_out_sel  <= {{(MD_OUT_SEL_WIDTH-1){1'b0}}, (op != MD_OP_MUL)};
            end else begin
              state           <= ST_DIV;
              div_first       <= 1'b1;
              mul_src1        <= '0;
              mul_src2        <= '0;
              mul_src1_signed <= 1'b0;
              mul_src2_signed <= 1'b0;
              mul_md_out_sel  <= '0;
            end
          end
        end
        ST_MUL: begin
          result <= mul_result;
          state  <= ST_DONE;
        end
        ST_DIV: begin
          if (div_first) begin
            div_first <= 1'b0;
            if (special) begin
              result <= special_result;
              state  <= ST_DONE;
            end
          end else if (iter_last) begin
            result <= fixed_result;
            state  <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: a vector table of M-extension ops with expected
// results and latencies, plus flush, held-start and async-reset sequences.
module tb_md_ctrl;
  import md_ctrl_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    logic [1:0]  sgn;
    logic        sel;
  } vec_t;

  logic                        clk;
  logic                        rst_n;
  logic                        start;
  logic [2:0]                  op;
  logic [31:0]                 src1;
  logic [31:0]                 src2;
  logic                        flush;
  logic                        busy;
  logic                        done;
  logic [31:0]                 result;
  logic [31:0]                 mul_src1;
  logic [31:0]                 mul_src2;
  logic                        mul_src1_signed;
  logic                        mul_src2_signed;
  logic [MD_OUT_SEL_WIDTH-1:0] mul_md_out_sel;
  logic [31:0]                 mul_result;

  int n_vec;
  int n_err;
  vec_t vecs[20];

  md_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .op              (op),
    .src1            (src1),
    .src2            (src2),
    .flush           (flush),
    .busy            (busy),
    .done            (done),
    .result          (result),
    .mul_src1        (mul_src1),
    .mul_src2        (mul_src2),
    .mul_src1_signed (mul_src1_signed),
    .mul_src2_signed (mul_src2_signed),
    .mul_md_out_sel  (mul_md_out_sel),
    .mul_result      (mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the shared combinational multiplier outside the block.
  logic [63:0] a64, b64, prod;
  assign a64 = mul_src1_signed ? {{32{mul_src1[31]}}, mul_src1} : {32'b0, mul_src1};
  assign b64 = mul_src2_signed ? {{32{mul_src2[31]}}, mul_src2} : {32'b0, mul_src2};
  assign prod = a64 * b64;
  assign mul_result = mul_md_out_sel[0] ? prod[63:32] : prod[31:0];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input string tag);
    int lat;
    @(posedge clk); #1;
    start = 1'b1; op = v.op; src1 = v.a; src2 = v.b;
    @(posedge clk); #1;
    start = 1'b0;
    check_output({tag, "_busy"}, 32'(busy), 32'd1);
    if (v.op < 3'd4) begin
      check_output({tag, "_sgn"}, 32'({mul_src1_signed, mul_src2_signed}), 32'(v.sgn));
      check_output({tag, "_sel"}, 32'(mul_md_out_sel), 32'(v.sel));
    end
    wait_done(lat);
    check_output({tag, "_lat"}, 32'(lat), 32'(v.lat));
    check_output({tag, "_result"}, result, v.exp);
    @(posedge clk); #1;
    check_output({tag, "_done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [31:0] prior;
    vec_t v;

    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; op = '0; src1 = '0; src2 = '0; flush = 1'b0;

    vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2,  2'b11, 1'b1};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2,  2'b00, 1'b1};
    vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 2,  2'b10, 1'b1};
    vecs[3]  = '{3'd0, 32'd7,        32'd6,        32'd42,       2,  2'b11, 1'b0};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 2'b00, 1'b0};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 2'b00, 1'b0};
    vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       34, 2'b00, 1'b0};
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        34, 2'b00, 1'b0};
    vecs[8]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 2,  2'b00, 1'b0};
    vecs[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,        2,  2'b00, 1'b0};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2,  2'b00, 1'b0};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2,  2'b00, 1'b0};
    vecs[12] = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 2'b00, 1'b0};
    vecs[13] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        34, 2'b00, 1'b0};
    vecs[14] = '{3'd4, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'd2,        34, 2'b00, 1'b0};
    vecs[15] = '{3'd6, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 34, 2'b00, 1'b0};
    vecs[16] = '{3'd4, 32'h80000000, 32'd2,        32'hC0000000, 34, 2'b00, 1'b0};
    vecs[17] = '{3'd7, 32'hFFFFFFFF, 32'd10,       32'd5,        34, 2'b00, 1'b0};
    vecs[18] = '{3'd4, 32'd0,        32'd5,        32'd0,        34, 2'b00, 1'b0};
    vecs[19] = '{3'd4, 32'hFFFFFFFD, 32'd0,        32'hFFFFFFFF, 2,  2'b00, 1'b0};

    #22 rst_n = 1'b1;
    #1;
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_result", result, 32'd0);
    check_output("rst_mul_src1", mul_src1, 32'd0);
    check_output("rst_mul_src2", mul_src2, 32'd0);
    check_output("rst_mul_ctl", 32'({mul_src1_signed, mul_src2_signed, mul_md_out_sel}), 32'd0);

    for (int i = 0; i < 20; i++)
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // Flush in the 10th cycle after the start is sampled.
    prior = result;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd5; src1 = 32'd100; src2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    check_output("flush_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    check_output("flush_busy_after", 32'(busy), 32'd0);
    check_output("flush_done", 32'(done), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    check_output("flush_no_done", 32'(pulses), 32'd0);
    check_output("flush_result_kept", result, prior);

    // start held through a whole op; operand changes while busy are ignored.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd5; src1 = 32'd100; src2 = 32'd7;
    @(posedge clk); #1;
    src1 = 32'd200;
    wait_done(lat);
    check_output("hold_lat1", 32'(lat), 32'd34);
    check_output("hold_result1", result, 32'd14);
    @(posedge clk); #1;
    check_output("hold_idle_gap", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check_output("hold_reaccept", 32'(busy), 32'd1);
    wait_done(lat);
    check_output("hold_lat2", 32'(lat), 32'd34);
    check_output("hold_result2", result, 32'd28);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a divide.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; src1 = 32'hFFFFFFF9; src2 = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_output("arst_busy", 32'(busy), 32'd0);
    check_output("arst_done", 32'(done), 32'd0);
    check_output("arst_result", result, 32'd0);
    #2 rst_n = 1'b1;
    v = '{3'd0, 32'd3, 32'd3, 32'd9, 2, 2'b11, 1'b0};
    apply_stimulus(v, "post_rst_mul");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
